// File: rtl/mem_bus_arbiter.sv
// Two-port memory bus arbiter: an instruction-fetch port and a load/store
// port share one memory bus. Round-robin under contention, one outstanding
// transaction at a time, optional timeout on the memory acknowledge.
// Handshake: a requester raises its req with stable address/data fields and
// holds them until it sees its one-cycle ack; the memory sees mem_req high
// with stable fields for the whole transaction and completes it with a
// one-cycle mem_ack (mem_rdata valid in that cycle). Every output is driven
// from a flop or a decode of flops, so there is no input-to-output path.
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic                  f_ack,
  output logic                  f_err,
  output logic [DATA_WIDTH-1:0] f_rdata,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Port identifiers used for the grant and the round-robin pointer.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // A zero TIMEOUT disables the timeout; keep the counter at least 1 bit wide.
  localparam bit              TO_EN   = (TIMEOUT > 0);
  localparam int              CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  gnt_q, gnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  f_ack_q, f_ack_d;
  logic                  f_err_q, f_err_d;
  logic [DATA_WIDTH-1:0] f_rdata_q, f_rdata_d;
  logic                  d_ack_q, d_ack_d;
  logic                  d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

  logic                  pick;
  logic [DATA_WIDTH-1:0] resp_data;

  // Next-state, grant selection and response generation.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    f_ack_d   = 1'b0;
    f_err_d   = 1'b0;
    f_rdata_d = '0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = '0;
    // Under contention the port that did not win last time goes first.
    pick      = (f_req && d_req) ? ~last_q : d_req;
    // Stores return zero data; loads and fetches return the memory word.
    resp_data = (gnt_q == PORT_DATA && we_q) ? '0 : mem_rdata;

    case (state_q)
      S_IDLE: begin
        if (f_req || d_req) begin
          state_d = S_BUSY;
          gnt_d   = pick;
          last_d  = pick;
          cnt_d   = '0;
          if (pick == PORT_DATA) begin
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            addr_d  = f_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end
      S_BUSY: begin
        // mem_ack is checked first so it wins a tie with the timeout.
        if (mem_ack) begin
          state_d = S_RESP;
          if (gnt_q == PORT_DATA) begin
            d_ack_d   = 1'b1;
            d_rdata_d = resp_data;
          end else begin
            f_ack_d   = 1'b1;
            f_rdata_d = resp_data;
          end
        end else if (TO_EN && cnt_q == TO_LAST) begin
          state_d = S_RESP;
          if (gnt_q == PORT_DATA) begin
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end else begin
            f_ack_d = 1'b1;
            f_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= PORT_DATA;
      gnt_q     <= PORT_FETCH;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      f_ack_q   <= 1'b0;
      f_err_q   <= 1'b0;
      f_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      f_ack_q   <= f_ack_d;
      f_err_q   <= f_err_d;
      f_rdata_q <= f_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Output decode from registered state only.
  always_comb begin
    mem_req   = (state_q == S_BUSY);
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
    mem_addr  = addr_q;
    mem_we    = we_q;
    mem_wdata = wdata_q;
    f_ack     = f_ack_q;
    f_err     = f_err_q;
    f_rdata   = f_rdata_q;
    d_ack     = d_ack_q;
    d_err     = d_err_q;
    d_rdata   = d_rdata_q;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter (TIMEOUT = 4). Inputs are driven 1 time unit
// after the rising edge (or on the falling edge); outputs are sampled on the
// falling edge. Expected responses {is_data, err, rdata} are queued when a
// transaction is started and popped by the response monitor on each ack.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_ack, f_err;
  logic [DW-1:0] f_rdata;
  logic          d_req = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic          d_we = 1'b0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack, d_err;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          busy;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW+1:0] exp_q[$];

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    logic [DW+1:0] got;
    logic [DW+1:0] exp;
    if (!rst && (f_ack || d_ack)) begin
      n_checks++;
      if (f_ack && d_ack) begin
        n_fail++;
        $display("FAIL both_acks: f_ack=%0b d_ack=%0b, required only one", f_ack, d_ack);
      end
      got = {d_ack, (d_ack ? d_err : f_err), (d_ack ? d_rdata : f_rdata)};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got %h, required no ack", got);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          n_fail++;
          $display("FAIL scoreboard: got {data,err,rdata}=%h, required %h", got, exp);
        end
      end
      n_checks++;
      if ((d_ack && (f_err || f_rdata != '0)) || (f_ack && (d_err || d_rdata != '0))) begin
        n_fail++;
        $display("FAIL idle_port_quiet: f_err=%0b f_rdata=%h d_err=%0b d_rdata=%h, required ungranted port 0",
                 f_err, f_rdata, d_err, d_rdata);
      end
    end
  end

  // Waits (bounded) for mem_req, returning on the falling edge where it is seen.
  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [3*DW+2*AW+10:0] all_out;
    f_req = 1'b1;
    f_addr = 32'h0000_0AAA;
    repeat (3) @(posedge clk);
    @(negedge clk);
    all_out = {f_ack, f_err, f_rdata, d_ack, d_err, d_rdata, mem_req, mem_addr,
               mem_we, mem_wdata, busy, dbg_state};
    n_checks++;
    if (all_out !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h, required 0", all_out);
    end
    f_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_no_grant: busy=%0b mem_req=%0b, required 0", busy, mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_single_load();
    bit ok;
    exp_q.push_back({1'b1, 1'b0, 32'hDEAD_BEEF});
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 32'h100; d_we = 1'b0; d_wdata = 32'h5555_5555;
    wait_mem_req(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL load_mem_req: got no mem_req, required within 20 cycles");
    end
    n_checks++;
    if (mem_addr !== 32'h100 || mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL load_fields: got addr=%h we=%0b, required addr=100 we=0", mem_addr, mem_we);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    mem_ack = 1'b0; d_req = 1'b0;
    n_checks++;
    if (d_ack !== 1'b1 || f_ack !== 1'b0 || d_rdata !== 32'hDEAD_BEEF || d_err !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ack: got d_ack=%0b f_ack=%0b d_rdata=%h d_err=%0b, required 1 0 deadbeef 0",
               d_ack, f_ack, d_rdata, d_err);
    end
    @(posedge clk); #1;
    n_checks++;
    if (d_ack !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL load_ack_pulse: got d_ack=%0b busy=%0b, required 0 0", d_ack, busy);
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [DW-1:0] rd;
    logic exp_port;
    @(posedge clk); #1;
    rst = 1'b1;
    f_req = 1'b1; f_addr = 32'h200;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0; d_wdata = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int t = 0; t < 4; t++) begin
      exp_port = t[0];
      rd = $urandom;
      wait_mem_req(ok);
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL contention_mem_req: txn %0d got no mem_req", t);
      end
      n_checks++;
      if (mem_addr !== (exp_port ? 32'h300 : 32'h200)) begin
        n_fail++;
        $display("FAIL contention_order: txn %0d got addr=%h, required %h", t, mem_addr,
                 (exp_port ? 32'h300 : 32'h200));
      end
      exp_q.push_back({exp_port, 1'b0, rd});
      mem_ack = 1'b1; mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (t == 3) begin
        f_req = 1'b0; d_req = 1'b0;
      end
      n_checks++;
      if (f_ack !== ~exp_port || d_ack !== exp_port) begin
        n_fail++;
        $display("FAIL contention_ack: txn %0d got f_ack=%0b d_ack=%0b", t, f_ack, d_ack);
      end
      @(posedge clk); #1;
      n_checks++;
      if (f_ack !== 1'b0 || d_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL contention_ack_pulse: txn %0d got f_ack=%0b d_ack=%0b, required 0 0",
                 t, f_ack, d_ack);
      end
    end
  endtask

  task automatic test_store();
    bit ok;
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 32'h40; d_we = 1'b1; d_wdata = 32'h1234_5678;
    wait_mem_req(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL store_mem_req: got no mem_req");
    end
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      n_checks++;
      if (mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678 || mem_addr !== 32'h40 || mem_req !== 1'b1) begin
        n_fail++;
        $display("FAIL store_fields: cycle %0d got req=%0b we=%0b wdata=%h addr=%h", i, mem_req,
                 mem_we, mem_wdata, mem_addr);
      end
    end
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0; d_req = 1'b0; d_we = 1'b0;
    n_checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL store_ack: got d_ack=%0b d_rdata=%h, required 1 0", d_ack, d_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    bit ok;
    int hi;
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h500;
    wait_mem_req(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_mem_req: got no mem_req");
    end
    hi = 0;
    while (mem_req && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    f_req = 1'b0;
    n_checks++;
    if (hi != 4) begin
      n_fail++;
      $display("FAIL timeout_len: got mem_req high %0d cycles, required 4", hi);
    end
    n_checks++;
    if (f_ack !== 1'b1 || f_err !== 1'b1 || f_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout_resp: got f_ack=%0b f_err=%0b f_rdata=%h, required 1 1 0",
               f_ack, f_err, f_rdata);
    end
    @(posedge clk); #1;
    mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({f_ack, f_err, f_rdata, d_ack, d_err, d_rdata, mem_req, busy} !== '0) begin
      n_fail++;
      $display("FAIL stray_ack: got f_ack=%0b f_err=%0b f_rdata=%h d_ack=%0b mem_req=%0b busy=%0b, required 0",
               f_ack, f_err, f_rdata, d_ack, mem_req, busy);
    end
  endtask

  task automatic test_tie();
    bit ok;
    exp_q.push_back({1'b0, 1'b0, 32'hCAFE_F00D});
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h600;
    wait_mem_req(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL tie_mem_req: got no mem_req");
    end
    repeat (3) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_ack = 1'b0; f_req = 1'b0;
    n_checks++;
    if (f_ack !== 1'b1 || f_err !== 1'b0 || f_rdata !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL tie_resp: got f_ack=%0b f_err=%0b f_rdata=%h, required 1 0 cafef00d",
               f_ack, f_err, f_rdata);
    end
    @(posedge clk); #1;
    n_checks++;
    if (f_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL tie_ack_pulse: got f_ack=%0b, required 0", f_ack);
    end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    logic [DW-1:0] rd;
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = 32'h700; d_we = 1'b0;
    wait_mem_req(ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rstbusy_mem_req: got no mem_req");
    end
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (mem_req !== 1'b0 || busy !== 1'b0 || d_ack !== 1'b0) begin
      n_fail++;
      $display("FAIL rstbusy_async: got mem_req=%0b busy=%0b d_ack=%0b, required 0 0 0",
               mem_req, busy, d_ack);
    end
    @(posedge clk); #1;
    d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (d_ack !== 1'b0 || f_ack !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rstbusy_no_ack: got d_ack=%0b f_ack=%0b busy=%0b, required 0", d_ack, f_ack, busy);
      end
    end
    rd = $urandom;
    @(posedge clk); #1;
    f_req = 1'b1; f_addr = 32'h800;
    d_req = 1'b1; d_addr = 32'h900;
    wait_mem_req(ok);
    n_checks++;
    if (!ok || mem_addr !== 32'h800) begin
      n_fail++;
      $display("FAIL rstbusy_first_grant: got ok=%0b addr=%h, required fetch addr 800", ok, mem_addr);
    end
    exp_q.push_back({1'b0, 1'b0, rd});
    mem_ack = 1'b1; mem_rdata = rd;
    @(posedge clk); #1;
    mem_ack = 1'b0; f_req = 1'b0; d_req = 1'b0;
    n_checks++;
    if (f_ack !== 1'b1) begin
      n_fail++;
      $display("FAIL rstbusy_fetch_ack: got f_ack=%0b, required 1", f_ack);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_single_load();
    test_contention();
    test_store();
    test_timeout();
    test_tie();
    test_reset_mid_busy();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending responses, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter TIMEOUT, default 255, cycles to wait for mem_ack; 0 disables timeout.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have clk, input, 1, clock; all state updates on its rising edge.
REQ-006 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have f_req, input, 1, instruction-fetch request, held until f_ack.
REQ-008 SHALL have f_addr, input, ADDR_WIDTH, fetch address, stable while f_req.
REQ-009 SHALL have f_ack, output, 1, one-cycle fetch completion pulse.
REQ-010 SHALL have f_err, output, 1, fetch timed out; valid only with f_ack.
REQ-011 SHALL have f_rdata, output, DATA_WIDTH, fetch read data; valid only with f_ack.
REQ-012 SHALL have d_req, input, 1, load/store request, held until d_ack.
REQ-013 SHALL have d_addr, input, ADDR_WIDTH, data address.
REQ-014 SHALL have d_we, input, 1, 1 = store, 0 = load.
REQ-015 SHALL have d_wdata, input, DATA_WIDTH, store data.
REQ-016 SHALL have d_ack, d_err and d_rdata, outputs, 1/1/DATA_WIDTH, same meaning as the fetch equivalents; d_rdata is 0 for stores.
REQ-017 SHALL have mem_req, output, 1, memory transaction active.
REQ-018 SHALL have mem_addr, mem_we and mem_wdata, outputs, ADDR_WIDTH/1/DATA_WIDTH, registered transaction fields.
REQ-019 SHALL have mem_ack, input, 1, memory completion pulse.
REQ-020 SHALL have mem_rdata, input, DATA_WIDTH, read data; valid with mem_ack.
REQ-021 SHALL have busy, output, 1, high whenever state is not IDLE.

Function
REQ-022 SHALL implement states IDLE, BUSY and RESP.
REQ-023 In IDLE with no request, SHALL remain in IDLE.
REQ-024 In IDLE with exactly one request, SHALL grant that request at the clock edge and enter BUSY.
REQ-025 In IDLE with both requests, SHALL grant the port that was not last_grant (round-robin).
REQ-026 SHALL update last_grant on every grant; its reset value is DATA, so the first contention goes to fetch.
REQ-027 On grant, SHALL register mem_addr, mem_we (0 for fetch) and mem_wdata (0 for fetch).
REQ-028 On grant, SHALL assert mem_req in the following cycle and keep it high for all of BUSY.
REQ-029 In BUSY, SHALL not change mem_addr, mem_we or mem_wdata.
REQ-030 In BUSY, on mem_ack=1 at an edge, SHALL register mem_rdata into the granted port's rdata (0 for stores), set err=0 and enter RESP.
REQ-031 In BUSY, SHALL count cycles in an internal counter of width clog2(TIMEOUT+1), cleared on grant.
REQ-032 When TIMEOUT>0 and the counter reaches TIMEOUT without mem_ack, SHALL enter RESP with err=1 and rdata=0.
REQ-033 When mem_ack and the timeout occur at the same edge, mem_ack SHALL win (err=0).
REQ-034 In RESP, SHALL hold mem_req=0 and pulse the granted port's ack for exactly one cycle.
REQ-035 In RESP, SHALL ignore all requests.
REQ-036 From RESP, SHALL return to IDLE; the requester must drop req or present a new request by the next cycle.
REQ-037 Minimum transaction timing is grant edge N, mem_req high N+1, mem_ack at N+1, ack at N+2, next grant N+3.
REQ-038 SHALL ignore mem_ack outside BUSY (stray ack).
REQ-039 SHALL hold the ungranted port's ack, err and rdata at 0.
REQ-040 A request that drops before grant SHALL not be granted.
REQ-041 SHALL have no combinational path from any input to any output.

Reset
REQ-042 rst=1 SHALL immediately (asynchronously) set state=IDLE and last_grant=DATA.
REQ-043 rst=1 SHALL immediately clear the counter and drive every output to 0: f_ack, f_err, f_rdata, d_ack, d_err, d_rdata, mem_req, mem_addr, mem_we, mem_wdata and busy.
REQ-044 Reset mid-transaction SHALL abandon the transfer, return no ack, and drop mem_req in the same cycle.
REQ-045 After rst deasserts, SHALL make the first grant no earlier than the first rising clk edge.

Verification
REQ-046 Single load: d_req=1, d_addr=0x100, d_we=0; mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, d_ack pulse with d_rdata=0xDEADBEEF, d_err=0, f_ack=0.
REQ-047 Contention: f_req and d_req held high together from reset for 4 transactions -> grant order fetch, data, fetch, data; each ack exactly one cycle.
REQ-048 Store: d_we=1, d_wdata=0x12345678, d_addr=0x40 -> mem_we=1, mem_wdata=0x12345678 throughout BUSY; d_ack with d_rdata=0.
REQ-049 Timeout: TIMEOUT=4, f_req with mem_ack never asserted -> mem_req high 4 cycles, then f_ack=1, f_err=1, f_rdata=0; a later stray mem_ack changes no output.
REQ-050 Tie: TIMEOUT=4, mem_ack on the timeout edge -> err=0 and rdata=mem_rdata.
REQ-051 Reset mid-BUSY: rst asserted two cycles into BUSY -> mem_req and busy go 0 without a clock edge, no ack occurs, and after release the next contention grants fetch.
